// File: rtl/peak_interval_detector.sv
// peak_interval_detector: finds strict local maxima over a +/-WIN sample window and reports beat intervals.
// Define HR_BPM_EN to add the serial BPM divider; otherwise bpm/bpm_valid are tied low.
module peak_interval_detector #(
  parameter int unsigned DATA_W  = 9,
  parameter int unsigned WIN     = 16,
  parameter int unsigned CNT_W   = 11,
  parameter int unsigned REFRACT = 40,
  parameter int unsigned MAX_GAP = 1500,
  parameter int unsigned BPM_NUM = 6000
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     sample_valid,
  input  logic signed [DATA_W-1:0] sample,
  input  logic signed [DATA_W-1:0] threshold,
  output logic                     peak,
  output logic [CNT_W-1:0]         interval,
  output logic                     interval_valid,
  output logic                     timeout,
  output logic [7:0]               bpm,
  output logic                     bpm_valid
);

  localparam int unsigned WLEN   = 2 * WIN + 1;
  localparam int unsigned FILL_W = $clog2(WLEN + 1);

  // Elaboration-time sanity check of the parameter set
  if (MAX_GAP == 0 || MAX_GAP >= (1 << CNT_W) || BPM_NUM == 0 || BPM_NUM > 65535 ||
      REFRACT > MAX_GAP) begin : g_param_check
    $error("peak_interval_detector: illegal parameter set");
  end

  typedef enum logic [1:0] {
    S_FILL   = 2'd0,
    S_NO_REF = 2'd1,
    S_ARMED  = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic signed [DATA_W-1:0] win_q   [WLEN];
  logic signed [DATA_W-1:0] win_nxt [WLEN];
  logic [FILL_W-1:0]        fill_q, fill_d;
  logic [CNT_W-1:0]         since_q, since_d;
  logic [CNT_W:0]           since_inc;
  logic                     cand;
  logic                     peak_q, peak_d;
  logic                     iv_q, iv_d;
  logic                     timeout_q, timeout_d;
  logic [CNT_W-1:0]         interval_q, interval_d;

  // Window as it will look after this strobe; detection is judged on this view
  always_comb begin
    win_nxt[0] = sample;
    for (int i = 1; i < WLEN; i++) begin
      win_nxt[i] = win_q[i-1];
    end
  end

  // Strict maximum at the centre that also clears the threshold
  always_comb begin
    cand = (win_nxt[WIN] >= threshold);
    for (int i = 0; i < WLEN; i++) begin
      if (i != int'(WIN) && win_nxt[i] >= win_nxt[WIN]) begin
        cand = 1'b0;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    fill_d     = fill_q;
    since_d    = since_q;
    peak_d     = 1'b0;
    iv_d       = 1'b0;
    timeout_d  = timeout_q;
    interval_d = interval_q;
    since_inc  = (CNT_W+1)'(since_q) + (CNT_W+1)'(1);

    if (sample_valid) begin
      since_d = (since_inc >= (CNT_W+1)'(MAX_GAP)) ? CNT_W'(MAX_GAP) : since_inc[CNT_W-1:0];
      case (state_q)
        S_FILL: begin
          fill_d = fill_q + FILL_W'(1);
          if (fill_q == FILL_W'(WLEN - 1)) begin
            state_d = S_NO_REF;
          end
        end
        S_NO_REF: begin
          if (cand) begin
            peak_d    = 1'b1;
            since_d   = '0;
            timeout_d = 1'b0;
            state_d   = S_ARMED;
          end
        end
        S_ARMED: begin
          // An accepted peak takes priority over a timeout on the same strobe
          if (cand && since_inc >= (CNT_W+1)'(REFRACT)) begin
            peak_d     = 1'b1;
            iv_d       = 1'b1;
            interval_d = since_inc[CNT_W-1:0];
            since_d    = '0;
            timeout_d  = 1'b0;
          end else if (since_d == CNT_W'(MAX_GAP)) begin
            timeout_d = 1'b1;
            state_d   = S_NO_REF;
          end
        end
        default: begin
          state_d = S_FILL;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_FILL;
      fill_q     <= '0;
      since_q    <= '0;
      peak_q     <= 1'b0;
      iv_q       <= 1'b0;
      timeout_q  <= 1'b0;
      interval_q <= '0;
      for (int i = 0; i < WLEN; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      fill_q     <= fill_d;
      since_q    <= since_d;
      peak_q     <= peak_d;
      iv_q       <= iv_d;
      timeout_q  <= timeout_d;
      interval_q <= interval_d;
      if (sample_valid) begin
        for (int i = 0; i < WLEN; i++) begin
          win_q[i] <= win_nxt[i];
        end
      end
    end
  end

  assign peak           = peak_q;
  assign interval       = interval_q;
  assign interval_valid = iv_q;
  assign timeout        = timeout_q;

`ifdef HR_BPM_EN
  localparam int unsigned QW = 16;
  localparam logic [QW-1:0] DIVIDEND = QW'(BPM_NUM);

  logic             busy_q;
  logic [4:0]       cnt_q;
  logic [QW-1:0]    quo_q;
  logic [CNT_W-1:0] rem_q;
  logic [CNT_W-1:0] dvs_q;
  logic [7:0]       bpm_q;
  logic             bpm_valid_q;
  logic [CNT_W:0]   rem_sh;
  logic [CNT_W-1:0] rem_sub;

  // One restoring-division step: bring down the next dividend bit, trial subtract
  always_comb begin
    rem_sh  = {rem_q, quo_q[QW-1]};
    rem_sub = CNT_W'(rem_sh - {1'b0, dvs_q});
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_q      <= 1'b0;
      cnt_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      bpm_q       <= '0;
      bpm_valid_q <= 1'b0;
    end else begin
      bpm_valid_q <= 1'b0;
      if (iv_d) begin
        busy_q <= 1'b1;
        cnt_q  <= 5'(QW);
        quo_q  <= DIVIDEND;
        rem_q  <= '0;
        dvs_q  <= interval_d;
      end else if (busy_q) begin
        if (cnt_q == '0) begin
          busy_q      <= 1'b0;
          bpm_valid_q <= 1'b1;
          bpm_q       <= (quo_q > QW'(255)) ? 8'hFF : quo_q[7:0];
        end else begin
          cnt_q <= cnt_q - 5'd1;
          if (rem_sh >= {1'b0, dvs_q}) begin
            rem_q <= rem_sub;
            quo_q <= {quo_q[QW-2:0], 1'b1};
          end else begin
            rem_q <= rem_sh[CNT_W-1:0];
            quo_q <= {quo_q[QW-2:0], 1'b0};
          end
        end
      end
    end
  end

  assign bpm       = bpm_q;
  assign bpm_valid = bpm_valid_q;
`else
  assign bpm       = '0;
  assign bpm_valid = 1'b0;
`endif

endmodule
